// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared state encoding, PS/2 command/response bytes and response helpers
package mouse_pkg;

    typedef enum logic [3:0] {
        INIT,
        TX_RST,
        WAIT_TX_RST,
        WAIT_ACK1RX,
        WAIT_STRX,
        WAIT_IDRX,
        TX_EN,
        WAIT_TX_EN,
        WAIT_ACK2RX,
        READ_B1,
        READ_B2,
        READ_B3,
        EMIT
    } state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    // Byte the mouse must answer with while the init FSM sits in a WAIT_*RX state.
    function automatic logic [7:0] rsp_expected(state_t s);
        case (s)
            WAIT_STRX: return RSP_SELFTEST;
            WAIT_IDRX: return RSP_ID;
            default:   return RSP_ACK;
        endcase
    endfunction

    function automatic state_t rx_next(state_t s);
        case (s)
            WAIT_ACK1RX: return WAIT_STRX;
            WAIT_STRX:   return WAIT_IDRX;
            WAIT_IDRX:   return TX_EN;
            default:     return READ_B1;
        endcase
    endfunction

endpackage

// File: rtl/mouse_master_sm_if.sv
// rtl/mouse_master_sm_if.sv - transmitter, receiver and packet-output signals of the mouse master
interface mouse_master_sm_if;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic       BYTE_READY;
    logic [1:0] BYTE_ERROR_CODE;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic       INIT_DONE;

    modport master (
        output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, INIT_DONE,
        input  BYTE_SENT, BYTE_READ, BYTE_READY, BYTE_ERROR_CODE
    );

    modport slave (
        input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, INIT_DONE,
        output BYTE_SENT, BYTE_READ, BYTE_READY, BYTE_ERROR_CODE
    );
endinterface

// File: rtl/mouse_packet_assembler.sv
// rtl/mouse_packet_assembler.sv - collects 3-byte movement packets and publishes them with an interrupt
module mouse_packet_assembler
    import mouse_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_byte_ready,
    input  logic [7:0] i_byte,
    input  logic [1:0] i_err,
    output logic       o_read_en,
    output logic [7:0] o_status,
    output logic [7:0] o_dx,
    output logic [7:0] o_dy,
    output logic       o_interrupt
);

    state_t     r_state;
    logic       r_read_en;
    logic [7:0] r_b1;
    logic [7:0] r_b2;
    logic [7:0] r_b3;
    logic [7:0] r_status;
    logic [7:0] r_dx;
    logic [7:0] r_dy;
    logic       r_interrupt;

    logic w_good;
    assign w_good = i_byte_ready && (i_err == 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= READ_B1;
            r_read_en   <= 1'b0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_b3        <= '0;
            r_status    <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_interrupt <= 1'b0;
        end else begin
            r_interrupt <= 1'b0;
            if (!i_enable) begin
                r_state   <= READ_B1;
                r_read_en <= 1'b0;
            end else begin
                case (r_state)
                    READ_B1: begin
                        r_read_en <= 1'b1;
                        // bit3 is always set in a status byte; anything else means we are out of sync
                        if (w_good && i_byte[3]) begin
                            r_b1    <= i_byte;
                            r_state <= READ_B2;
                        end
                    end
                    READ_B2: begin
                        if (i_byte_ready) begin
                            if (w_good) begin
                                r_b2    <= i_byte;
                                r_state <= READ_B3;
                            end else begin
                                r_state <= READ_B1;
                            end
                        end
                    end
                    READ_B3: begin
                        if (i_byte_ready) begin
                            if (w_good) begin
                                r_b3      <= i_byte;
                                r_state   <= EMIT;
                                r_read_en <= 1'b0;
                            end else begin
                                r_state <= READ_B1;
                            end
                        end
                    end
                    EMIT: begin
                        r_status    <= r_b1;
                        r_dx        <= r_b2;
                        r_dy        <= r_b3;
                        r_interrupt <= 1'b1;
                        r_read_en   <= 1'b1;
                        r_state     <= READ_B1;
                    end
                    default: begin
                        r_state <= READ_B1;
                    end
                endcase
            end
        end
    end

    assign o_read_en   = r_read_en;
    assign o_status    = r_status;
    assign o_dx        = r_dx;
    assign o_dy        = r_dy;
    assign o_interrupt = r_interrupt;

endmodule

// File: rtl/mouse_master_sm.sv
// rtl/mouse_master_sm.sv - PS/2 mouse init sequencer with timeout; streaming handed to the packet assembler
module mouse_master_sm
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic CLK,
    input  logic RESET,
    mouse_master_sm_if.master bus
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_send_byte;
    logic [7:0]       r_byte_to_send;
    logic             r_read_en;
    logic             r_init_done;

    logic w_rx_ok;
    logic w_rx_fail;
    logic w_asm_read_en;

    assign w_rx_ok   = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00)
                    && (bus.BYTE_READ == rsp_expected(r_state));
    assign w_rx_fail = bus.BYTE_READY ? !w_rx_ok : (r_cnt == LP_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state        <= INIT;
            r_cnt          <= '0;
            r_send_byte    <= 1'b0;
            r_byte_to_send <= '0;
            r_read_en      <= 1'b0;
            r_init_done    <= 1'b0;
        end else begin
            r_send_byte <= 1'b0;
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                INIT: begin
                    if (r_cnt == LP_LAST) begin
                        r_state <= TX_RST;
                        r_cnt   <= '0;
                    end
                end
                TX_RST: begin
                    r_send_byte    <= 1'b1;
                    r_byte_to_send <= CMD_RESET;
                    r_state        <= WAIT_TX_RST;
                    r_cnt          <= '0;
                end
                WAIT_TX_RST: begin
                    if (bus.BYTE_SENT) begin
                        r_state   <= WAIT_ACK1RX;
                        r_cnt     <= '0;
                        r_read_en <= 1'b1;
                    end
                end
                WAIT_ACK1RX, WAIT_STRX, WAIT_IDRX, WAIT_ACK2RX: begin
                    if (w_rx_ok) begin
                        r_state   <= rx_next(r_state);
                        r_cnt     <= '0;
                        // receiver stays on except for the hop into TX_EN
                        r_read_en <= (r_state != WAIT_IDRX);
                        if (r_state == WAIT_ACK2RX) begin
                            r_init_done <= 1'b1;
                        end
                    end else if (w_rx_fail) begin
                        r_state     <= INIT;
                        r_cnt       <= '0;
                        r_read_en   <= 1'b0;
                        r_init_done <= 1'b0;
                    end
                end
                TX_EN: begin
                    r_send_byte    <= 1'b1;
                    r_byte_to_send <= CMD_ENABLE;
                    r_state        <= WAIT_TX_EN;
                    r_cnt          <= '0;
                end
                WAIT_TX_EN: begin
                    if (bus.BYTE_SENT) begin
                        r_state   <= WAIT_ACK2RX;
                        r_cnt     <= '0;
                        r_read_en <= 1'b1;
                    end
                end
                READ_B1: begin
                    // the assembler drives the receiver enable from here on
                    r_read_en <= 1'b0;
                end
                default: begin
                    r_state     <= INIT;
                    r_cnt       <= '0;
                    r_read_en   <= 1'b0;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    mouse_packet_assembler u_asm (
        .i_clk        (CLK),
        .i_rst_n      (RESET),
        .i_enable     (r_init_done),
        .i_byte_ready (bus.BYTE_READY),
        .i_byte       (bus.BYTE_READ),
        .i_err        (bus.BYTE_ERROR_CODE),
        .o_read_en    (w_asm_read_en),
        .o_status     (bus.MOUSE_STATUS),
        .o_dx         (bus.MOUSE_DX),
        .o_dy         (bus.MOUSE_DY),
        .o_interrupt  (bus.SEND_INTERRUPT)
    );

    assign bus.SEND_BYTE    = r_send_byte;
    assign bus.BYTE_TO_SEND = r_byte_to_send;
    assign bus.READ_ENABLE  = r_read_en | w_asm_read_en;
    assign bus.INIT_DONE    = r_init_done;

endmodule

// File: tb/tb_mouse_master_sm.sv
// tb/tb_mouse_master_sm.sv - directed self-checking bench for mouse_master_sm
module tb_mouse_master_sm;
    import mouse_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   irq_cnt;
    int   irq_base;
    int   n;

    mouse_master_sm_if bus_if ();

    mouse_master_sm #(
        .TIMEOUT_CYCLES (100),
        .CNT_W          (8)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial irq_cnt = 0;
    always @(negedge clk) begin
        if (bus_if.SEND_INTERRUPT) irq_cnt <= irq_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!bus_if.SEND_BYTE && cycles < 300);
    endtask

    // Holds the command for a few cycles, then completes it with one BYTE_SENT pulse.
    task automatic complete_tx(input logic [7:0] cmd);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tx_hold", {24'd0, bus_if.BYTE_TO_SEND}, {24'd0, cmd});
            check("tx_pulse_low", {31'd0, bus_if.SEND_BYTE}, 32'd0);
        end
        bus_if.BYTE_SENT = 1'b1;
        tick();
        bus_if.BYTE_SENT = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b, input logic [1:0] e);
        int k;
        k = 0;
        while (!bus_if.READ_ENABLE && k < 200) begin
            tick();
            k++;
        end
        check("rx_read_en", {31'd0, bus_if.READ_ENABLE}, 32'd1);
        bus_if.BYTE_READ       = b;
        bus_if.BYTE_ERROR_CODE = e;
        bus_if.BYTE_READY      = 1'b1;
        tick();
        bus_if.BYTE_READY      = 1'b0;
        bus_if.BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_send"},   {31'd0, bus_if.SEND_BYTE}, 32'd0);
        check({tag, "_tbyte"},  {24'd0, bus_if.BYTE_TO_SEND}, 32'd0);
        check({tag, "_re"},     {31'd0, bus_if.READ_ENABLE}, 32'd0);
        check({tag, "_status"}, {24'd0, bus_if.MOUSE_STATUS}, 32'd0);
        check({tag, "_dx"},     {24'd0, bus_if.MOUSE_DX}, 32'd0);
        check({tag, "_dy"},     {24'd0, bus_if.MOUSE_DY}, 32'd0);
        check({tag, "_irq"},    {31'd0, bus_if.SEND_INTERRUPT}, 32'd0);
        check({tag, "_done"},   {31'd0, bus_if.INIT_DONE}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus_if.BYTE_SENT       = 1'b0;
        bus_if.BYTE_READ       = 8'h00;
        bus_if.BYTE_READY      = 1'b0;
        bus_if.BYTE_ERROR_CODE = 2'b00;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // power-up wait then reset command
        wait_send(n);
        check("ff_cycle", n, 32'd101);
        check("ff_byte", {24'd0, bus_if.BYTE_TO_SEND}, {24'd0, CMD_RESET});
        check("ff_re_off", {31'd0, bus_if.READ_ENABLE}, 32'd0);
        complete_tx(CMD_RESET);
        check("ack1_re_on", {31'd0, bus_if.READ_ENABLE}, 32'd1);

        // wrong self-test reply falls back to INIT
        rx(RSP_ACK, 2'b00);
        rx(8'hFC, 2'b00);
        check("bad_st_re_off", {31'd0, bus_if.READ_ENABLE}, 32'd0);
        wait_send(n);
        check("bad_st_resend_cycle", n, 32'd101);
        check("bad_st_resend_byte", {24'd0, bus_if.BYTE_TO_SEND}, {24'd0, CMD_RESET});
        complete_tx(CMD_RESET);

        // silent mouse: response timeout
        n = 0;
        do begin
            tick();
            n++;
        end while (bus_if.READ_ENABLE && n < 300);
        check("timeout_cycle", n, 32'd100);
        check("timeout_done", {31'd0, bus_if.INIT_DONE}, 32'd0);
        wait_send(n);
        check("timeout_resend_cycle", n, 32'd101);
        check("timeout_resend_byte", {24'd0, bus_if.BYTE_TO_SEND}, {24'd0, CMD_RESET});
        complete_tx(CMD_RESET);

        // full init
        rx(RSP_ACK, 2'b00);
        rx(RSP_SELFTEST, 2'b00);
        rx(RSP_ID, 2'b00);
        check("txen_re_off", {31'd0, bus_if.READ_ENABLE}, 32'd0);
        wait_send(n);
        check("f4_seen", {31'd0, bus_if.SEND_BYTE}, 32'd1);
        check("f4_byte", {24'd0, bus_if.BYTE_TO_SEND}, {24'd0, CMD_ENABLE});
        complete_tx(CMD_ENABLE);
        check("ack2_done_low", {31'd0, bus_if.INIT_DONE}, 32'd0);
        rx(RSP_ACK, 2'b00);
        check("init_done", {31'd0, bus_if.INIT_DONE}, 32'd1);
        check("init_status0", {24'd0, bus_if.MOUSE_STATUS}, 32'd0);

        // first packet and its latency
        irq_base = irq_cnt;
        rx(8'h08, 2'b00);
        rx(8'h05, 2'b00);
        rx(8'hFB, 2'b00);
        check("pk1_irq_early", {31'd0, bus_if.SEND_INTERRUPT}, 32'd0);
        check("pk1_emit_re", {31'd0, bus_if.READ_ENABLE}, 32'd0);
        tick();
        check("pk1_irq", {31'd0, bus_if.SEND_INTERRUPT}, 32'd1);
        check("pk1_status", {24'd0, bus_if.MOUSE_STATUS}, 32'h08);
        check("pk1_dx", {24'd0, bus_if.MOUSE_DX}, 32'h05);
        check("pk1_dy", {24'd0, bus_if.MOUSE_DY}, 32'hFB);
        tick();
        check("pk1_irq_off", {31'd0, bus_if.SEND_INTERRUPT}, 32'd0);
        check("pk1_irq_count", irq_cnt - irq_base, 32'd1);

        // out-of-sync byte discarded
        irq_base = irq_cnt;
        rx(8'h00, 2'b00);
        rx(8'h09, 2'b00);
        rx(8'h01, 2'b00);
        rx(8'h02, 2'b00);
        tick();
        tick();
        check("pk2_irq_count", irq_cnt - irq_base, 32'd1);
        check("pk2_status", {24'd0, bus_if.MOUSE_STATUS}, 32'h09);
        check("pk2_dx", {24'd0, bus_if.MOUSE_DX}, 32'h01);
        check("pk2_dy", {24'd0, bus_if.MOUSE_DY}, 32'h02);

        // parity error on byte 2, then a partial packet, then async reset
        irq_base = irq_cnt;
        rx(8'h0A, 2'b00);
        rx(8'h55, 2'b01);
        rx(8'h0B, 2'b00);
        rx(8'h22, 2'b00);
        repeat (3) tick();
        check("pk3_irq_count", irq_cnt - irq_base, 32'd0);
        check("pk3_status_hold", {24'd0, bus_if.MOUSE_STATUS}, 32'h09);
        check("pk3_dx_hold", {24'd0, bus_if.MOUSE_DX}, 32'h01);
        check("pk3_dy_hold", {24'd0, bus_if.MOUSE_DY}, 32'h02);
        check("pk3_done", {31'd0, bus_if.INIT_DONE}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
